// File: rtl/col_sched_pkg.sv
// rtl/col_sched_pkg.sv - shared types and default sizes for the column scheduler
//
// Purpose: FSM state encoding and default geometry for column_scheduler and
// its round-robin arbiter.
// Ports: none (package).

package col_sched_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 128;
  localparam int unsigned COL_MAX_SIZE_DEF = 4;
  localparam int unsigned LEN_W_DEF        = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the next pending column
//
// Purpose: returns the first set bit of req at or after ptr, wrapping around.
// Ports:
//   req        in   N      pending requesters
//   ptr        in   IDX_W  search start index
//   grant      out  N      one-hot grant (zero when nothing pending)
//   grant_idx  out  IDX_W  index of the granted requester
//   grant_vld  out  1      some requester was granted

module rr_arbiter
  import col_sched_pkg::*;
#(
  parameter int unsigned N     = COL_MAX_SIZE_DEF,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] idx;

  // Walk N positions starting at ptr; explicit wrap keeps non-power-of-two N correct.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = ptr;
    for (int k = 0; k < int'(N); k++) begin
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_vld  = 1'b1;
      end
      idx = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/column_scheduler.sv
// rtl/column_scheduler.sv - drains per-column FWFT FIFOs into one engine, round-robin
//
// Purpose: after partition_done, serves every column with a non-zero length
// one at a time in round-robin order for exactly its programmed beat count,
// then pulses process_done.
// Ports:
//   user_clk         in   clock
//   user_rst         in   synchronous active-low reset
//   partition_done   in   pulse: column FIFOs loaded, col_len valid
//   col_len          in   beats per column {c3..c0}
//   data_fifo_dout   in   FWFT FIFO heads {c3..c0}
//   data_fifo_empty  in   per-column empty flags
//   data_fifo_rd_en  out  per-column pop, at most one bit set
//   eng_tdata/tvalid/tlast/tcol out, eng_tready in   engine stream
//   process_done     out  pulse: all columns drained
//   busy             out  run in progress

module column_scheduler
  import col_sched_pkg::*;
#(
  parameter int unsigned TCQ           = 1,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned COL_MAX_SIZE  = COL_MAX_SIZE_DEF,
  parameter int unsigned LEN_W         = LEN_W_DEF,
  localparam int unsigned COL_W        = $clog2(COL_MAX_SIZE)
) (
  input  logic                               user_clk,
  input  logic                               user_rst,
  input  logic                               partition_done,
  input  logic [COL_MAX_SIZE*LEN_W-1:0]      col_len,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] data_fifo_dout,
  input  logic [COL_MAX_SIZE-1:0]            data_fifo_empty,
  output logic [COL_MAX_SIZE-1:0]            data_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]              eng_tdata,
  output logic                               eng_tvalid,
  output logic                               eng_tlast,
  output logic [COL_W-1:0]                   eng_tcol,
  input  logic                               eng_tready,
  output logic                               process_done,
  output logic                               busy
);

  // Registered assignments carry no delay; TCQ is accepted for drop-in
  // compatibility with the surrounding design and only range-checked.
  if (TCQ > 1000) begin : g_tcq_check
    $error("column_scheduler: TCQ out of range");
  end

  state_t                  state, next_state;
  logic [LEN_W-1:0]        len_q [COL_MAX_SIZE];
  logic [COL_MAX_SIZE-1:0] pend_mask;
  logic [COL_MAX_SIZE-1:0] sel_oh;
  logic [COL_W-1:0]        rr_ptr;
  logic [COL_W-1:0]        sel;
  logic [LEN_W-1:0]        beat_cnt;
  logic [LEN_W-1:0]        cur_len;

  logic [COL_MAX_SIZE-1:0] grant;
  logic [COL_W-1:0]        grant_idx;
  logic                    grant_vld;
  logic                    fire;

  rr_arbiter #(
    .N     (COL_MAX_SIZE),
    .IDX_W (COL_W)
  ) u_arb (
    .req       (pend_mask),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign eng_tcol = sel;

  always_ff @(posedge user_clk) begin
    if (!user_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and all stream outputs. The head of the selected FIFO is
  // passed straight through: a pop happens in the same cycle as the handshake.
  always_comb begin
    next_state      = state;
    eng_tvalid      = 1'b0;
    eng_tlast       = 1'b0;
    data_fifo_rd_en = '0;
    process_done    = 1'b0;
    fire            = 1'b0;
    eng_tdata       = '0;
    cur_len         = '0;
    for (int i = 0; i < int'(COL_MAX_SIZE); i++) begin
      if (sel == COL_W'(i)) begin
        eng_tdata = data_fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
        cur_len   = len_q[i];
      end
    end

    case (state)
      ST_IDLE: begin
        if (partition_done) begin
          next_state = ST_ARB;
        end
      end
      ST_ARB: begin
        next_state = grant_vld ? ST_STREAM : ST_DONE;
      end
      ST_STREAM: begin
        eng_tvalid = !data_fifo_empty[sel];
        // cur_len is non-zero here: only columns with a length are granted.
        eng_tlast  = eng_tvalid && (beat_cnt == cur_len - LEN_W'(1));
        fire       = eng_tvalid && eng_tready;
        if (fire) begin
          data_fifo_rd_en = sel_oh;
          if (eng_tlast) begin
            next_state = ST_ARB;
          end
        end
      end
      ST_DONE: begin
        process_done = 1'b1;
        next_state   = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst) begin
      for (int i = 0; i < int'(COL_MAX_SIZE); i++) begin
        len_q[i] <= '0;
      end
      pend_mask <= '0;
      sel_oh    <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (partition_done) begin
            for (int i = 0; i < int'(COL_MAX_SIZE); i++) begin
              len_q[i]     <= col_len[i*LEN_W +: LEN_W];
              pend_mask[i] <= |col_len[i*LEN_W +: LEN_W];
            end
            busy <= 1'b1;
          end
        end
        ST_ARB: begin
          if (grant_vld) begin
            sel      <= grant_idx;
            sel_oh   <= grant;
            beat_cnt <= '0;
          end
        end
        ST_STREAM: begin
          if (fire) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (eng_tlast) begin
              pend_mask <= pend_mask & ~sel_oh;
              rr_ptr    <= (sel == COL_W'(COL_MAX_SIZE - 1)) ? '0 : sel + COL_W'(1);
            end
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_column_scheduler.sv
// tb/tb_column_scheduler.sv - scoreboard bench for column_scheduler

module tb_column_scheduler;

  localparam int DW = 128;
  localparam int NC = 4;
  localparam int LW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    col;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              pd;
  logic [NC*LW-1:0]  col_len;
  logic [NC*DW-1:0]  dout;
  logic [NC-1:0]     empty;
  logic [NC-1:0]     rd_en;
  logic [DW-1:0]     tdata;
  logic              tvalid;
  logic              tlast;
  logic [1:0]        tcol;
  logic              tready;
  logic              process_done;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q [NC][$];
  beat_t         exp_q [$];
  int            model_ptr = 0;
  int            done_cnt  = 0;
  int            valid_cnt = 0;
  int            c1_beats  = 0;
  bit            gate_en     = 1'b0;
  bit            gate_closed = 1'b0;
  bit            rand_ready  = 1'b0;

  always #5 clk = ~clk;

  column_scheduler dut (
    .user_clk        (clk),
    .user_rst        (rst),
    .partition_done  (pd),
    .col_len         (col_len),
    .data_fifo_dout  (dout),
    .data_fifo_empty (empty),
    .data_fifo_rd_en (rd_en),
    .eng_tdata       (tdata),
    .eng_tvalid      (tvalid),
    .eng_tlast       (tlast),
    .eng_tcol        (tcol),
    .eng_tready      (tready),
    .process_done    (process_done),
    .busy            (busy)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fill the FIFO model with fresh data and push the expected beat order.
  task automatic load_run(input logic [NC*LW-1:0] lens);
    int    len [NC];
    bit    pend [NC];
    int    c;
    beat_t b;
    for (int i = 0; i < NC; i++) begin
      fifo_q[i].delete();
      len[i]  = int'(lens[i*LW +: LW]);
      pend[i] = (len[i] != 0);
      for (int k = 0; k < len[i]; k++) begin
        fifo_q[i].push_back({$urandom, $urandom, $urandom, $urandom});
      end
    end
    for (int n = 0; n < NC; n++) begin
      c = -1;
      for (int k = 0; k < NC; k++) begin
        if (c < 0 && pend[(model_ptr + k) % NC]) c = (model_ptr + k) % NC;
      end
      if (c >= 0) begin
        for (int k = 0; k < len[c]; k++) begin
          b.data = fifo_q[c][k];
          b.col  = 2'(c);
          b.last = (k == len[c] - 1);
          exp_q.push_back(b);
        end
        pend[c]   = 1'b0;
        model_ptr = (c + 1) % NC;
      end
    end
    col_len = lens;
  endtask

  task automatic pulse_pd();
    @(posedge clk); #1;
    pd = 1'b1;
    @(posedge clk); #1;
    pd = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!process_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", DW'(process_done), DW'(1));
    check_eq("busy_in_done", DW'(busy), DW'(1));
    @(negedge clk);
    check_eq("done_one_cycle", DW'(process_done), DW'(0));
    check_eq("busy_after_done", DW'(busy), DW'(0));
    check_eq("scoreboard_empty", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic run(input logic [NC*LW-1:0] lens, input int budget);
    int d0;
    d0 = done_cnt;
    load_run(lens);
    pulse_pd();
    wait_done(budget);
    @(posedge clk); #1;
    check_eq("done_count", DW'(done_cnt - d0), DW'(1));
  endtask

  // FWFT FIFO model: pops sampled mid-cycle are applied just after the edge.
  initial begin : fifo_model
    logic [NC-1:0] pops;
    bit            hold;
    forever begin
      @(negedge clk);
      pops = rd_en;
      hold = tvalid && !tready;
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++) begin
        if (pops[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
      end
      if (!gate_en) gate_closed = 1'b0;
      else if (!hold) gate_closed = !gate_closed;
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < NC; i++) begin
        empty[i] = (fifo_q[i].size() == 0) || gate_closed;
        dout[i*DW +: DW] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : '0;
      end
    end
  end

  initial begin : monitor
    beat_t         e;
    logic [DW-1:0] held = '0;
    bit            stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
        continue;
      end
      if (process_done) done_cnt++;
      if (tvalid) valid_cnt++;
      if (stalled) begin
        check_eq("stall_valid_held", DW'(tvalid), DW'(1));
        check_eq("stall_data_held", tdata, held);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", DW'(1), DW'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_col", DW'(tcol), DW'(e.col));
          check_eq("beat_data", tdata, e.data);
          check_eq("beat_last", DW'(tlast), DW'(e.last));
          check_eq("beat_rd_en", DW'(rd_en), DW'(4'b0001 << e.col));
        end
        if (tcol == 2'd1) c1_beats++;
      end else begin
        check_eq("rd_en_idle", DW'(rd_en), DW'(0));
      end
      stalled = tvalid && !tready;
      held    = tdata;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int v0;
    int d0;
    int n;
    rst     = 1'b0;
    pd      = 1'b0;
    col_len = '0;
    tready  = 1'b1;
    empty   = '1;
    dout    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", DW'(tvalid), DW'(0));
    check_eq("rst_tlast", DW'(tlast), DW'(0));
    check_eq("rst_rd_en", DW'(rd_en), DW'(0));
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_done", DW'(process_done), DW'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: lengths 1..4, everything ready
    run({16'd4, 16'd3, 16'd2, 16'd1}, 400);

    // 2: only c1 (2 beats) and c3 (5 beats)
    run({16'd5, 16'd0, 16'd2, 16'd0}, 400);

    // 3: all zero -> process_done two cycles after partition_done
    v0 = valid_cnt;
    load_run('0);
    @(posedge clk); #1;
    pd = 1'b1;
    @(negedge clk);
    check_eq("zero_done_c0", DW'(process_done), DW'(0));
    @(posedge clk); #1;
    pd = 1'b0;
    @(negedge clk);
    check_eq("zero_done_c1", DW'(process_done), DW'(0));
    check_eq("zero_busy_c1", DW'(busy), DW'(1));
    @(negedge clk);
    check_eq("zero_done_c2", DW'(process_done), DW'(1));
    @(negedge clk);
    check_eq("zero_done_c3", DW'(process_done), DW'(0));
    check_eq("zero_busy_c3", DW'(busy), DW'(0));
    @(posedge clk); #1;
    check_eq("zero_no_valid", DW'(valid_cnt - v0), DW'(0));

    // 4: c0 only, 8 beats, FIFO gated on alternate cycles, random ready
    gate_en    = 1'b1;
    rand_ready = 1'b1;
    run({16'd0, 16'd0, 16'd0, 16'd8}, 2000);
    gate_en    = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // 5: second partition_done during STREAM is ignored
    d0 = done_cnt;
    v0 = valid_cnt;
    load_run({16'd8, 16'd8, 16'd8, 16'd8});
    pulse_pd();
    n = 0;
    while (valid_cnt == v0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("repulse_stream_started", DW'(valid_cnt != v0), DW'(1));
    col_len = {16'd3, 16'd3, 16'd3, 16'd3};
    pulse_pd();
    wait_done(600);
    v0 = valid_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_eq("repulse_done_count", DW'(done_cnt - d0), DW'(1));
    check_eq("repulse_no_rerun", DW'(valid_cnt - v0), DW'(0));
    check_eq("repulse_busy", DW'(busy), DW'(0));

    // 6: reset in the middle of column c1, then a fresh run from c0
    d0       = done_cnt;
    c1_beats = 0;
    load_run({16'd1, 16'd1, 16'd6, 16'd1});
    pulse_pd();
    n = 0;
    while (c1_beats < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("c1_reached_beat2", DW'(c1_beats >= 2), DW'(1));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_tvalid", DW'(tvalid), DW'(0));
    check_eq("midrst_tlast", DW'(tlast), DW'(0));
    check_eq("midrst_rd_en", DW'(rd_en), DW'(0));
    check_eq("midrst_busy", DW'(busy), DW'(0));
    check_eq("midrst_done", DW'(process_done), DW'(0));
    exp_q.delete();
    for (int i = 0; i < NC; i++) fifo_q[i].delete();
    model_ptr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_eq("midrst_no_done", DW'(done_cnt - d0), DW'(0));
    repeat (2) @(posedge clk);
    #1;
    run({16'd2, 16'd2, 16'd2, 16'd2}, 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
